// File: rtl/gol_pkg.sv
// gol_pkg: shared state encoding, default geometry/pacing and pattern select codes
// for the Game of Life seed controller.
package gol_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, PAUSE} state_t;
    localparam int ROWS_DEF     = 8;
    localparam int COLS_DEF     = 8;
    localparam int STEP_DIV_DEF = 25_000_000;
    localparam logic [1:0] PAT_GLIDER  = 2'd0;
    localparam logic [1:0] PAT_BLINKER = 2'd1;
    localparam logic [1:0] PAT_BEACON  = 2'd2;
    localparam logic [1:0] PAT_ACORN   = 2'd3;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchronizer for a raw button followed by a one-cycle
// rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic evt_o
);
    logic [2:0] sh_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= {sh_q[1:0], btn_i};
    end
    assign evt_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/gol_seed_ctrl.sv
// gol_seed_ctrl: latches the pattern choice, streams the pattern ROM into the grid
// row-major, then paces generation steps. GOL_SINGLE_STEP_EN adds a PAUSE step button.
module gol_seed_ctrl
    import gol_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              sw_sel,
    input  logic                    load_btn,
`ifdef GOL_SINGLE_STEP_EN
    input  logic                    step_btn,
`endif
    input  logic                    run_sw,
    input  logic                    step_busy,
    input  logic                    seed_bit,
    output logic [1:0]              sel,
    output logic [$clog2(ROWS)-1:0] pat_row,
    output logic [$clog2(COLS)-1:0] pat_col,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] wr_row,
    output logic [$clog2(COLS)-1:0] wr_col,
    output logic                    wr_data,
    output logic                    step,
    output logic                    busy
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(STEP_DIV);

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [RW-1:0]   row_q, row_d, wr_row_q;
    logic [CW-1:0]   col_q, col_d, wr_col_q;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d, wr_en_q, wr_data_q;
    logic            load_evt, last_col, last_row, expire, step_ok;

    btn_edge u_load (.clk(clk), .rst_n(rst_n), .btn_i(load_btn), .evt_o(load_evt));

`ifdef GOL_SINGLE_STEP_EN
    logic step_evt;
    btn_edge u_step (.clk(clk), .rst_n(rst_n), .btn_i(step_btn), .evt_o(step_evt));
    assign step_ok = (state_q == RUN) || (state_q == PAUSE);
`else
    assign step_ok = (state_q == RUN);
`endif

    assign last_col = (col_q == CW'(COLS - 1));
    assign last_row = (row_q == RW'(ROWS - 1));
    assign expire   = (state_q == RUN) && run_sw && (cnt_q == DW'(STEP_DIV - 1));
    assign step     = step_ok && pend_q && !step_busy;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q & ~step;
        // A new load restarts from any settled state; LOAD and DRAIN ignore it.
        if (load_evt && (state_q == IDLE || state_q == RUN || state_q == PAUSE)) begin
            state_d = LOAD;
            sel_d   = sw_sel;
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    col_d   = last_col ? '0 : col_q + 1'b1;
                    row_d   = !last_col ? row_q : (last_row ? '0 : row_q + 1'b1);
                    state_d = (last_col && last_row) ? DRAIN : LOAD;
                end
                DRAIN: state_d = run_sw ? RUN : PAUSE;
                RUN: begin
                    state_d = run_sw ? RUN : PAUSE;
                    cnt_d   = !run_sw ? cnt_q : (expire ? '0 : cnt_q + 1'b1);
                    pend_d  = pend_d | expire;
                end
                PAUSE: begin
                    state_d = run_sw ? RUN : PAUSE;
`ifdef GOL_SINGLE_STEP_EN
                    pend_d  = pend_d | step_evt;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            wr_en_q   <= (state_q == LOAD);
            wr_row_q  <= row_q;
            wr_col_q  <= col_q;
            wr_data_q <= seed_bit;
        end
    end

    assign sel     = sel_q;
    assign pat_row = row_q;
    assign pat_col = col_q;
    assign wr_en   = wr_en_q;
    assign wr_row  = wr_row_q;
    assign wr_col  = wr_col_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == LOAD) || (state_q == DRAIN);
endmodule
